mm_sa_driver: RTL and testbench
===============================

# mm_sa_driver

Bus initiator for the memory-mapped 2x2 systolic-array peripheral. It accepts one operand set per command and drives the peripheral's `wen`/`addr`/`wdata`/`rdata` register port through a fixed sequence:

- reset the array
- load the four operands
- start
- poll status until done
- read the four results back

It sits between a local command source (CPU-less test harness or DMA front end) and the peripheral, and returns the results on a valid/ready channel.

## Interface
- `MAX_POLLS`, 256: status reads returning not-done before timeout.
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  high only in IDLE.
- `north0`, `north1`, `west0`, `west1`  in  32 each  operands; sampled on the cmd handshake cycle.
- `res_valid`  out  1  results available; held until accepted.
- `res_ready`  in  1  consumer accepts.
- `result0`..`result3`  out  32 each  captured RESULT_00/01/10/11.
- `res_timeout`  out  1  qualifies `res_valid`; results are zero when set.
- `wen`  out  4  4'hF on write cycles, 4'h0 otherwise.
- `addr`  out  22  `{14'h0, reg_index}`.
- `wdata`  out  32  write data; 0 when not writing.
- `rdata`  in  32  peripheral read data.

## Operation
- Register indices: CONTROL 0x00, STATUS 0x01, NORTH_0 0x02, NORTH_1 0x03, WEST_0 0x04, WEST_1 0x05, RESULT_00..RESULT_11 0x06..0x09.
- CONTROL fields: [7:0] reset, [15:8] start, [23:16] shift_n_flow.
- CONTROL words written by this block:
  - CTRL_RST = 32'h0000_0001
  - CTRL_START = 32'h0000_0100
  - CTRL_IDLE = 32'h0000_0000
- Peripheral read contract: `rdata` is registered. An address presented with `wen`=0 in cycle t is valid on `rdata` in cycle t+1. STATUS[0] lags the array's done by one further cycle.
- States and sequence:
  - IDLE: on `cmd_valid`, latch the operands and go to WR_RST.
  - WR_RST: write CTRL_RST.
  - RST_WAIT: 2 cycles, read STATUS, result discarded.
  - WR_N0, WR_N1, WR_W0, WR_W1: write the latched operands.
  - WR_START: write CTRL_START.
  - POLL_REQ: read STATUS.
  - POLL_CHK: sample `rdata[0]`.
    - 1: go to RD0.
    - 0 and poll count < MAX_POLLS: increment the count, go back to POLL_REQ.
    - Otherwise: timeout, go to WR_IDLE.
  - RD0..RD3: issue reads 0x06..0x09 on consecutive cycles.
    - Each `rdata` is captured the following cycle into `result0..3`.
    - The RESULT_11 capture happens in the WR_IDLE cycle.
  - WR_IDLE: write CTRL_IDLE.
  - OUT: `res_valid`=1; on `res_ready`, go to IDLE.
- Timeout path: clear `result0..3` to 0, set `res_timeout`=1, skip RD0..RD3.
- Poll counter width is `$clog2(MAX_POLLS+1)`. It clears on entry to WR_START.
- No arithmetic on data; the 32-bit values pass through unchanged.

## Timing
- Reset values:
  - state IDLE, so `cmd_ready`=1
  - `wen`=0, `addr`=0, `wdata`=0
  - `res_valid`=0, `res_timeout`=0
  - `result0..3`=0
  - poll counter 0
- All bus outputs and `res_*` are registered. `cmd_ready` is decoded from state.
- Command accepted in cycle 0, done seen on the first poll:
  - WR_RST: cycle 1
  - operand writes: cycles 4-7
  - start: cycle 8
  - STATUS read: cycle 9, checked in cycle 10
  - result reads: cycles 11-14
  - CTRL_IDLE write: cycle 15
  - `res_valid`: cycle 16
- Each extra not-done poll adds 2 cycles.
- Timeout `res_valid` arrives at cycle 12 + 2·MAX_POLLS.
- `res_valid` stays high with stable outputs until `res_ready`. `cmd_ready` stays low throughout, so there is no overlap between the output and the next command.
- `cmd_valid` outside IDLE is ignored, and operand inputs are don't-care.
- `reset` mid-sequence: next cycle is IDLE with `wen`=0 and all outputs at reset values. The peripheral CONTROL register is left as-is; the next command's WR_RST reinitialises it.
- `res_timeout` clears on the OUT handshake.

## Structure
- Shared package `mm_sa_pkg`:
  - register index constants
  - CTRL_RST / CTRL_START / CTRL_IDLE
  - CONTROL field bit positions
  - driver state enum
- Single module; no sub-module warranted. The capture logic is a 4-entry register file indexed by a 2-bit read pointer delayed one cycle.

## Test plan
- Reset then one command (north 1,2; west 3,4) against the peripheral model, done on first poll:
  - bus trace matches the exact address/wdata sequence above
  - `res_valid` at cycle 16
  - results equal the model outputs
  - `res_timeout`=0
- Done delayed 5 polls: 6 STATUS reads, `res_valid` at cycle 26, results correct.
- Done never asserted, MAX_POLLS=4: `res_timeout`=1, results 0, no RESULT reads on the bus, CTRL_IDLE written.
- Backpressure: `res_ready` low for 10 cycles after `res_valid`:
  - outputs held stable
  - `cmd_ready`=0 throughout
  - `cmd_valid` pulses ignored
- `reset` asserted during the poll phase: next cycle `wen`=0 and state IDLE. A following command completes correctly with the stale CONTROL overwritten by CTRL_RST.
- Back-to-back commands with `res_ready` tied high: the second command is accepted the cycle after the OUT handshake, and the second results are independent of the first.

Source files
------------

// File: rtl/mm_sa_pkg.sv
// Shared definitions for the 2x2 systolic-array peripheral and its bus driver:
// register map, CONTROL words and the driver state encoding.
`timescale 1ns/1ps
package mm_sa_pkg;

  localparam logic [7:0] REG_CONTROL   = 8'h00;
  localparam logic [7:0] REG_STATUS    = 8'h01;
  localparam logic [7:0] REG_NORTH_0   = 8'h02;
  localparam logic [7:0] REG_NORTH_1   = 8'h03;
  localparam logic [7:0] REG_WEST_0    = 8'h04;
  localparam logic [7:0] REG_WEST_1    = 8'h05;
  localparam logic [7:0] REG_RESULT_00 = 8'h06;

  localparam int CTRL_RESET_LSB = 0;
  localparam int CTRL_START_LSB = 8;
  localparam int CTRL_SHIFT_LSB = 16;

  localparam logic [31:0] CTRL_RST   = 32'h0000_0001;
  localparam logic [31:0] CTRL_START = 32'h0000_0100;
  localparam logic [31:0] CTRL_IDLE  = 32'h0000_0000;

  localparam logic [3:0] WEN_ALL = 4'hF;

  // RD0..RD3 share the top two bits so the low bits double as the result index
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_WR_RST   = 4'd1,
    S_RST_WAIT = 4'd2,
    S_WR_N0    = 4'd3,
    S_WR_N1    = 4'd4,
    S_WR_W0    = 4'd5,
    S_WR_W1    = 4'd6,
    S_WR_START = 4'd7,
    S_POLL_REQ = 4'd8,
    S_POLL_CHK = 4'd9,
    S_WR_IDLE  = 4'd10,
    S_OUT      = 4'd11,
    S_RD0      = 4'd12,
    S_RD1      = 4'd13,
    S_RD2      = 4'd14,
    S_RD3      = 4'd15
  } drv_state_e;

  function automatic logic [21:0] reg_addr(input logic [7:0] idx);
    return {14'h0, idx};
  endfunction

  function automatic logic is_rd(input drv_state_e s);
    return s[3:2] == 2'b11;
  endfunction

endpackage

// File: rtl/mm_sa_if.sv
// Register port of the systolic-array peripheral: byte write enables,
// word address, write data and registered read data.
`timescale 1ns/1ps
interface mm_sa_if;
  logic [3:0]  wen;
  logic [21:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output wen, output addr, output wdata, input rdata);
  modport slave  (input wen, input addr, input wdata, output rdata);
endinterface

// File: rtl/mm_sa_driver.sv
// Bus initiator: takes one operand set per command, runs reset/load/start/poll/
// readback on the peripheral and returns the four results on a valid/ready channel.
//
// state      | meaning
// IDLE       | waiting for a command, cmd_ready high
// WR_RST     | write CTRL_RST
// RST_WAIT   | two STATUS reads while the array resets (data discarded)
// WR_N0..W1  | write latched operands
// WR_START   | write CTRL_START
// POLL_REQ   | present STATUS read
// POLL_CHK   | inspect STATUS[0]: done, retry, or time out
// RD0..RD3   | present RESULT_00..RESULT_11 reads
// WR_IDLE    | write CTRL_IDLE (last result captured here)
// OUT        | res_valid high until res_ready
`timescale 1ns/1ps
module mm_sa_driver
  import mm_sa_pkg::*;
#(
  parameter int MAX_POLLS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] north0,
  input  logic [31:0] north1,
  input  logic [31:0] west0,
  input  logic [31:0] west1,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] result0,
  output logic [31:0] result1,
  output logic [31:0] result2,
  output logic [31:0] result3,
  output logic        res_timeout,
  mm_sa_if.master     bus
);

  localparam int PollW = $clog2(MAX_POLLS + 1);

  drv_state_e       state_q, state_d;
  logic [0:0]       wait_q, wait_d;
  logic [PollW-1:0] poll_q, poll_d;

  logic [3:0][31:0] op_q, op_d;
  logic [3:0][31:0] res_q, res_d;
  logic             cap_vld_q, cap_vld_d;
  logic [1:0]       cap_ptr_q, cap_ptr_d;
  logic             timeout_q, timeout_d;
  logic             res_valid_q, res_valid_d;
  logic [3:0]       wen_q, wen_d;
  logic [21:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;

  logic poll_exhausted;
  logic timeout_hit;

  assign poll_exhausted = poll_q >= PollW'(MAX_POLLS);
  assign timeout_hit    = (state_q == S_POLL_CHK) && !bus.rdata[0] && poll_exhausted;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      poll_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      poll_q  <= poll_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    poll_d  = poll_q;
    case (state_q)
      S_IDLE:     if (cmd_valid) state_d = S_WR_RST;
      S_WR_RST: begin
        state_d = S_RST_WAIT;
        wait_d  = 1'b1;
      end
      S_RST_WAIT: begin
        if (wait_q == 1'b0) state_d = S_WR_N0;
        else                wait_d  = wait_q - 1'b1;
      end
      S_WR_N0:    state_d = S_WR_N1;
      S_WR_N1:    state_d = S_WR_W0;
      S_WR_W0:    state_d = S_WR_W1;
      S_WR_W1: begin
        state_d = S_WR_START;
        poll_d  = '0;
      end
      S_WR_START: state_d = S_POLL_REQ;
      S_POLL_REQ: state_d = S_POLL_CHK;
      S_POLL_CHK: begin
        if (bus.rdata[0]) begin
          state_d = S_RD0;
        end else if (!poll_exhausted) begin
          poll_d  = poll_q + PollW'(1);
          state_d = S_POLL_REQ;
        end else begin
          state_d = S_WR_IDLE;
        end
      end
      S_RD0:      state_d = S_RD1;
      S_RD1:      state_d = S_RD2;
      S_RD2:      state_d = S_RD3;
      S_RD3:      state_d = S_WR_IDLE;
      S_WR_IDLE:  state_d = S_OUT;
      S_OUT:      if (res_ready) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Bus registers are loaded from the next state so each access appears in the
  // same cycle the FSM occupies the corresponding state.
  always_comb begin
    op_d        = op_q;
    res_d       = res_q;
    timeout_d   = timeout_q;
    cap_vld_d   = is_rd(state_q);
    cap_ptr_d   = state_q[1:0];
    res_valid_d = (state_d == S_OUT);
    wen_d       = '0;
    addr_d      = '0;
    wdata_d     = '0;

    if (state_q == S_IDLE && cmd_valid) op_d = {west1, west0, north1, north0};
    if (cap_vld_q) res_d[cap_ptr_q] = bus.rdata;
    if (timeout_hit) begin
      res_d     = '0;
      timeout_d = 1'b1;
    end
    if (state_q == S_OUT && res_ready) timeout_d = 1'b0;

    case (state_d)
      S_WR_RST: begin
        wen_d   = WEN_ALL;
        addr_d  = reg_addr(REG_CONTROL);
        wdata_d = CTRL_RST;
      end
      S_RST_WAIT, S_POLL_REQ: addr_d = reg_addr(REG_STATUS);
      S_WR_N0: begin
        wen_d   = WEN_ALL;
        addr_d  = reg_addr(REG_NORTH_0);
        wdata_d = op_q[0];
      end
      S_WR_N1: begin
        wen_d   = WEN_ALL;
        addr_d  = reg_addr(REG_NORTH_1);
        wdata_d = op_q[1];
      end
      S_WR_W0: begin
        wen_d   = WEN_ALL;
        addr_d  = reg_addr(REG_WEST_0);
        wdata_d = op_q[2];
      end
      S_WR_W1: begin
        wen_d   = WEN_ALL;
        addr_d  = reg_addr(REG_WEST_1);
        wdata_d = op_q[3];
      end
      S_WR_START: begin
        wen_d   = WEN_ALL;
        addr_d  = reg_addr(REG_CONTROL);
        wdata_d = CTRL_START;
      end
      S_RD0, S_RD1, S_RD2, S_RD3: addr_d = reg_addr(REG_RESULT_00 + {6'd0, state_d[1:0]});
      S_WR_IDLE: begin
        wen_d   = WEN_ALL;
        addr_d  = reg_addr(REG_CONTROL);
        wdata_d = CTRL_IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q        <= '0;
      res_q       <= '0;
      cap_vld_q   <= 1'b0;
      cap_ptr_q   <= '0;
      timeout_q   <= 1'b0;
      res_valid_q <= 1'b0;
      wen_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      op_q        <= op_d;
      res_q       <= res_d;
      cap_vld_q   <= cap_vld_d;
      cap_ptr_q   <= cap_ptr_d;
      timeout_q   <= timeout_d;
      res_valid_q <= res_valid_d;
      wen_q       <= wen_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign res_valid   = res_valid_q;
  assign res_timeout = timeout_q;
  assign result0     = res_q[0];
  assign result1     = res_q[1];
  assign result2     = res_q[2];
  assign result3     = res_q[3];
  assign bus.wen     = wen_q;
  assign bus.addr    = addr_q;
  assign bus.wdata   = wdata_q;

endmodule

// File: tb/tb_mm_sa_driver.sv
// Directed bench for mm_sa_driver: a behavioural peripheral behind the default
// instance and a never-done responder behind a MAX_POLLS=4 instance.
`timescale 1ns/1ps
module tb_mm_sa_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        cmd_valid;
  logic        sel;
  logic        res_ready;
  logic [31:0] north0, north1, west0, west1;
  logic        t_done;

  int n_cmp = 0;
  int n_mis = 0;

  mm_sa_if m_bus();
  mm_sa_if t_bus();

  logic        m_cmd_valid, t_cmd_valid;
  logic        m_cmd_ready, m_res_valid, m_res_timeout;
  logic        t_cmd_ready, t_res_valid, t_res_timeout;
  logic [31:0] m_r0, m_r1, m_r2, m_r3, t_r0, t_r1, t_r2, t_r3;

  assign m_cmd_valid = cmd_valid & ~sel;
  assign t_cmd_valid = cmd_valid & sel;

  mm_sa_driver dut (
    .clk(clk), .reset(reset),
    .cmd_valid(m_cmd_valid), .cmd_ready(m_cmd_ready),
    .north0(north0), .north1(north1), .west0(west0), .west1(west1),
    .res_valid(m_res_valid), .res_ready(res_ready),
    .result0(m_r0), .result1(m_r1), .result2(m_r2), .result3(m_r3),
    .res_timeout(m_res_timeout), .bus(m_bus.master)
  );

  mm_sa_driver #(.MAX_POLLS(4)) dut_t (
    .clk(clk), .reset(reset),
    .cmd_valid(t_cmd_valid), .cmd_ready(t_cmd_ready),
    .north0(north0), .north1(north1), .west0(west0), .west1(west1),
    .res_valid(t_res_valid), .res_ready(res_ready),
    .result0(t_r0), .result1(t_r1), .result2(t_r2), .result3(t_r3),
    .res_timeout(t_res_timeout), .bus(t_bus.master)
  );

  // peripheral model: result_ij = west_i * north_j, STATUS done after p_done_after busy reads
  logic [31:0]      p_ctrl = '0;
  logic [3:0][31:0] p_op   = '0;
  logic [3:0][31:0] p_res  = '0;
  logic             p_busy = 1'b0;
  int               p_reads = 0;
  int               p_done_after = 0;

  always @(posedge clk) begin
    if (m_bus.wen == 4'hF) begin
      case (m_bus.addr)
        22'd0: begin
          p_ctrl <= m_bus.wdata;
          if (m_bus.wdata[0]) begin
            p_busy  <= 1'b0;
            p_reads <= 0;
            p_res   <= '0;
          end else if (m_bus.wdata[8]) begin
            p_busy   <= 1'b1;
            p_reads  <= 0;
            p_res[0] <= p_op[2] * p_op[0];
            p_res[1] <= p_op[2] * p_op[1];
            p_res[2] <= p_op[3] * p_op[0];
            p_res[3] <= p_op[3] * p_op[1];
          end
        end
        22'd2: p_op[0] <= m_bus.wdata;
        22'd3: p_op[1] <= m_bus.wdata;
        22'd4: p_op[2] <= m_bus.wdata;
        22'd5: p_op[3] <= m_bus.wdata;
        default: ;
      endcase
    end else if (m_bus.addr == 22'd1 && p_busy) begin
      p_reads <= p_reads + 1;
    end
    case (m_bus.addr)
      22'd0:   m_bus.rdata <= p_ctrl;
      22'd1:   m_bus.rdata <= {31'd0, p_busy && (p_reads >= p_done_after)};
      22'd2:   m_bus.rdata <= p_op[0];
      22'd3:   m_bus.rdata <= p_op[1];
      22'd4:   m_bus.rdata <= p_op[2];
      22'd5:   m_bus.rdata <= p_op[3];
      22'd6:   m_bus.rdata <= p_res[0];
      22'd7:   m_bus.rdata <= p_res[1];
      22'd8:   m_bus.rdata <= p_res[2];
      22'd9:   m_bus.rdata <= p_res[3];
      default: m_bus.rdata <= '0;
    endcase
  end

  always @(posedge clk)
    t_bus.rdata <= (t_bus.addr == 22'd1) ? {31'd0, t_done} : {8'hA5, 2'b00, t_bus.addr};

  logic        s_cmd_ready, s_res_valid, s_res_timeout;
  logic [3:0]  s_wen;
  logic [21:0] s_addr;
  logic [31:0] s_wdata, s_r0, s_r1, s_r2, s_r3;

  always_comb begin
    s_cmd_ready   = sel ? t_cmd_ready   : m_cmd_ready;
    s_res_valid   = sel ? t_res_valid   : m_res_valid;
    s_res_timeout = sel ? t_res_timeout : m_res_timeout;
    s_wen         = sel ? t_bus.wen     : m_bus.wen;
    s_addr        = sel ? t_bus.addr    : m_bus.addr;
    s_wdata       = sel ? t_bus.wdata   : m_bus.wdata;
    s_r0          = sel ? t_r0 : m_r0;
    s_r1          = sel ? t_r1 : m_r1;
    s_r2          = sel ? t_r2 : m_r2;
    s_r3          = sel ? t_r3 : m_r3;
  end

  logic [57:0] tr [64];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where res_valid is first seen
  // (vcyc = cycles after the accept cycle), at cycle abort_k (vcyc = 0), or -1.
  task automatic run_cmd(input logic [31:0] a0, a1, b0, b1, input int abort_k,
                         output int acc_wait, output int vcyc);
    north0 = a0; north1 = a1; west0 = b0; west1 = b1;
    cmd_valid = 1'b1;
    acc_wait = 0;
    while (!s_cmd_ready && acc_wait < 8) begin
      @(negedge clk);
      acc_wait++;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    north0 = '1; north1 = '1; west0 = '1; west1 = '1;
    vcyc = -1;
    for (int k = 1; k < 64; k++) begin
      @(negedge clk);
      tr[k] = {s_wen, s_addr, s_wdata};
      if (s_res_valid) begin
        vcyc = k;
        break;
      end
      if (k == abort_k) begin
        vcyc = 0;
        break;
      end
    end
  endtask

  task automatic accept();
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    @(negedge clk);
    chk("post_accept_valid", {63'd0, s_res_valid}, 64'd0);
    chk("post_accept_ready", {63'd0, s_cmd_ready}, 64'd1);
  endtask

  function automatic logic [57:0] exp_first(input int k);
    case (k)
      1:             return {4'hF, 22'd0, 32'h1};
      2, 3, 9:       return {4'h0, 22'd1, 32'h0};
      4:             return {4'hF, 22'd2, 32'd1};
      5:             return {4'hF, 22'd3, 32'd2};
      6:             return {4'hF, 22'd4, 32'd3};
      7:             return {4'hF, 22'd5, 32'd4};
      8:             return {4'hF, 22'd0, 32'h100};
      11, 12, 13, 14: return {4'h0, 22'(k - 5), 32'h0};
      15:            return {4'hF, 22'd0, 32'h0};
      default:       return '0;
    endcase
  endfunction

  function automatic int count_addr(input int lo, input int hi, input int a_lo, input int a_hi);
    int n = 0;
    for (int k = lo; k <= hi; k++)
      if (tr[k][57:54] == 4'h0 && int'(tr[k][53:32]) >= a_lo && int'(tr[k][53:32]) <= a_hi) n++;
    return n;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int aw, vc;
    sel = 1'b0; reset = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0; t_done = 1'b1;
    north0 = '0; north1 = '0; west0 = '0; west1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", {63'd0, m_cmd_ready}, 64'd1);
    chk("rst_bus", {6'd0, m_bus.wen, m_bus.addr, m_bus.wdata}, 64'd0);
    chk("rst_res_flags", {62'd0, m_res_valid, m_res_timeout}, 64'd0);
    chk("rst_results", {m_r0 | m_r1, m_r2 | m_r3}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // single command, done on first poll
    run_cmd(32'd1, 32'd2, 32'd3, 32'd4, 0, aw, vc);
    chk("t1_valid_cycle", 64'(vc), 64'd16);
    for (int k = 1; k <= 15; k++) chk($sformatf("t1_trace_c%0d", k), {6'd0, tr[k]}, {6'd0, exp_first(k)});
    chk("t1_res01", {s_r0, s_r1}, {32'd3, 32'd6});
    chk("t1_res23", {s_r2, s_r3}, {32'd4, 32'd8});
    chk("t1_timeout", {63'd0, s_res_timeout}, 64'd0);
    accept();

    // done after 5 not-done polls, then backpressure with ignored cmd pulses
    p_done_after = 5;
    run_cmd(32'd5, 32'd6, 32'd7, 32'd8, 0, aw, vc);
    chk("t2_valid_cycle", 64'(vc), 64'd26);
    chk("t2_status_reads", 64'(count_addr(9, vc, 1, 1)), 64'd6);
    chk("t2_res01", {s_r0, s_r1}, {32'd35, 32'd42});
    chk("t2_res23", {s_r2, s_r3}, {32'd40, 32'd48});
    for (int i = 0; i < 10; i++) begin
      cmd_valid = ~i[0];
      north0 = 32'(i); west0 = 32'(i + 100);
      @(negedge clk);
      chk($sformatf("bp_ctl%0d", i), {60'd0, s_res_valid, s_cmd_ready, s_res_timeout, s_wen == 4'h0}, 64'b1001);
      chk($sformatf("bp_res01_%0d", i), {s_r0, s_r1}, {32'd35, 32'd42});
      chk($sformatf("bp_res23_%0d", i), {s_r2, s_r3}, {32'd40, 32'd48});
    end
    cmd_valid = 1'b0;
    accept();

    // MAX_POLLS=4 instance: one good run to load results, then a timeout
    p_done_after = 0;
    sel = 1'b1;
    t_done = 1'b1;
    run_cmd(32'd0, 32'd0, 32'd0, 32'd0, 0, aw, vc);
    chk("t3a_valid_cycle", 64'(vc), 64'd16);
    chk("t3a_res03", {s_r0, s_r3}, {32'hA500_0006, 32'hA500_0009});
    accept();
    t_done = 1'b0;
    run_cmd(32'd1, 32'd1, 32'd1, 32'd1, 0, aw, vc);
    chk("t3_valid_cycle", 64'(vc), 64'd20);
    chk("t3_timeout", {63'd0, s_res_timeout}, 64'd1);
    chk("t3_res01", {s_r0, s_r1}, 64'd0);
    chk("t3_res23", {s_r2, s_r3}, 64'd0);
    chk("t3_result_reads", 64'(count_addr(1, 19, 6, 9)), 64'd0);
    chk("t3_status_reads", 64'(count_addr(9, 19, 1, 1)), 64'd5);
    chk("t3_ctrl_idle", {6'd0, tr[19]}, {6'd0, 4'hF, 22'd0, 32'h0});
    accept();
    chk("t3_timeout_clr", {63'd0, s_res_timeout}, 64'd0);
    sel = 1'b0;

    // reset during polling, then a clean command
    p_done_after = 100;
    run_cmd(32'd9, 32'd9, 32'd9, 32'd9, 12, aw, vc);
    chk("t4_abort_reached", 64'(vc), 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("t4_rst_bus", {6'd0, m_bus.wen, m_bus.addr, m_bus.wdata}, 64'd0);
    chk("t4_rst_state", {62'd0, m_cmd_ready, m_res_valid}, 64'b10);
    @(negedge clk);
    reset = 1'b0;
    chk("t4_stale_ctrl", {32'd0, p_ctrl}, 64'h100);
    p_done_after = 0;
    @(negedge clk);
    run_cmd(32'd2, 32'd3, 32'd5, 32'd7, 0, aw, vc);
    chk("t4_valid_cycle", 64'(vc), 64'd16);
    chk("t4_ctrl_rst", {6'd0, tr[1]}, {6'd0, 4'hF, 22'd0, 32'h1});
    chk("t4_res01", {s_r0, s_r1}, {32'd10, 32'd15});
    chk("t4_res23", {s_r2, s_r3}, {32'd14, 32'd21});
    accept();

    // back-to-back with res_ready high
    run_cmd(32'd10, 32'd20, 32'd1, 32'd2, 0, aw, vc);
    chk("t5a_valid_cycle", 64'(vc), 64'd16);
    chk("t5a_res01", {s_r0, s_r1}, {32'd10, 32'd20});
    chk("t5a_res23", {s_r2, s_r3}, {32'd20, 32'd40});
    res_ready = 1'b1;
    run_cmd(32'd3, 32'd0, 32'd0, 32'd5, 0, aw, vc);
    chk("t5b_accept_wait", 64'(aw), 64'd1);
    chk("t5b_valid_cycle", 64'(vc), 64'd16);
    chk("t5b_res01", {s_r0, s_r1}, {32'd0, 32'd0});
    chk("t5b_res23", {s_r2, s_r3}, {32'd15, 32'd0});
    @(posedge clk);
    #1;
    chk("t5b_handshake", {62'd0, s_res_valid, s_cmd_ready}, 64'b01);
    res_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
